vram_cpu_port: RTL and testbench

// - LSPC CPU-side VRAM port: VRAMADDR/VRAMRW/VRAMMOD registers, modulo address step, write-data latch, read prefetch.
// - Sits directly upstream of the slow (low, 0000-7FFF) and fast (high, 8000-87FF) VRAM cycle blocks.
// - Drives VRAM_ADDR, VRAM_WRITE and nCPU_WR_* into them; captures their read data into the VRAMRW read latch.

---
 rtl/vram_cpu_port.sv | 147 ++++++++++++++
 tb/tb_vram_cpu_port.sv | 498 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_cpu_port.sv
// LSPC CPU-side VRAM port: address/data/modulo registers,
// modulo step, read prefetch and a 1-entry command queue.
module vram_cpu_port #(
  parameter bit          PREFETCH_EN = 1'b1,
  parameter logic [15:0] MOD_RST     = 16'h0001
) (
  input  logic        CLK_24M,
  input  logic        nRESET,
  input  logic [1:0]  REG_SEL,
  input  logic        CPU_WR,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic [14:0] VRAM_ADDR,
  output logic [15:0] VRAM_WRITE,
  output logic        nCPU_WR_LOW,
  output logic        nCPU_WR_HIGH,
  output logic        REQ_LOW,
  output logic        REQ_HIGH,
  input  logic        ACK_LOW,
  input  logic [15:0] VRAM_LOW_READ,
  input  logic        ACK_HIGH,
  input  logic [15:0] VRAM_HIGH_READ,
  output logic        BUSY,
  output logic        OVERRUN
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_PEND = 2'd1,
    RD_PEND = 2'd2
  } state_t;

  localparam state_t AFTER_ADDR =
    PREFETCH_EN ? RD_PEND : IDLE;

  state_t      state;
  logic [15:0] addr_reg;
  logic [15:0] mod_reg;
  logic [15:0] rd_latch;
  logic [15:0] wr_data;
  logic        q_valid;
  logic        q_is_rw;
  logic [15:0] q_data;
  logic        overrun;

  logic        bank;
  logic        idle;
  logic        ack;
  logic        cmd_in;
  logic        mod_wr;
  logic        go;
  logic        go_rw;
  logic [15:0] go_data;
  logic        q_issue;
  logic        q_drop;
  logic        q_store;
  logic [15:0] addr_step;

  assign bank = addr_reg[15];
  assign idle = (state == IDLE);

  // Command decode, queue arbitration and address step
  always_comb begin
    ack       = bank ? ACK_HIGH : ACK_LOW;
    cmd_in    = CPU_WR && !REG_SEL[1];
    mod_wr    = CPU_WR && (REG_SEL == 2'd2);
    q_issue   = idle && q_valid;
    q_drop    = cmd_in && !idle && q_valid;
    q_store   = cmd_in && (!idle || q_valid) && !q_drop;
    go        = idle && (q_valid || cmd_in);
    go_rw     = q_valid ? q_is_rw : REG_SEL[0];
    go_data   = q_valid ? q_data : CPU_DIN;
    addr_step = {addr_reg[15],
                 addr_reg[14:0] + mod_reg[14:0]};
  end

  // Access FSM, registers and the single-entry queue
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state    <= IDLE;
      addr_reg <= 16'h0000;
      mod_reg  <= MOD_RST;
      rd_latch <= 16'h0000;
      wr_data  <= 16'h0000;
      q_valid  <= 1'b0;
      q_is_rw  <= 1'b0;
      q_data   <= 16'h0000;
      overrun  <= 1'b0;
    end else begin
      if (mod_wr) mod_reg <= CPU_DIN;
      unique case (state)
        IDLE: begin
          if (go) begin
            if (go_rw) begin
              wr_data <= go_data;
              state   <= WR_PEND;
            end else begin
              addr_reg <= go_data;
              state    <= AFTER_ADDR;
            end
          end
        end
        WR_PEND: begin
          if (ack) begin
            addr_reg <= addr_step;
            state    <= AFTER_ADDR;
          end
        end
        RD_PEND: begin
          if (ack) begin
            rd_latch <= bank ? VRAM_HIGH_READ
                             : VRAM_LOW_READ;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (q_issue) q_valid <= 1'b0;
      if (q_store) begin
        q_valid <= 1'b1;
        q_is_rw <= REG_SEL[0];
        q_data  <= CPU_DIN;
      end
      if (q_drop) overrun <= 1'b1;
    end
  end

  // CPU read mux
  always_comb begin
    unique case (REG_SEL)
      2'd0:    CPU_DOUT = addr_reg;
      2'd1:    CPU_DOUT = rd_latch;
      2'd2:    CPU_DOUT = mod_reg;
      default: CPU_DOUT = 16'h0000;
    endcase
  end

  assign VRAM_ADDR    = addr_reg[14:0];
  assign VRAM_WRITE   = wr_data;
  assign REQ_LOW      = !idle && !bank;
  assign REQ_HIGH     = !idle && bank;
  assign nCPU_WR_LOW  = !((state == WR_PEND) && !bank);
  assign nCPU_WR_HIGH = !((state == WR_PEND) && bank);
  assign BUSY         = !idle || q_valid;
  assign OVERRUN      = overrun;

endmodule

// File: tb/tb_vram_cpu_port.sv
// Testbench for vram_cpu_port: directed scenarios plus
// randomized command stream against a register/memory model.
module tb_vram_cpu_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  reg_sel = 2'd0;
  logic        cpu_wr = 1'b0;
  logic [15:0] cpu_din = 16'h0000;
  logic [15:0] cpu_dout;
  logic [14:0] vram_addr;
  logic [15:0] vram_write;
  logic        n_wr_low, n_wr_high;
  logic        req_low, req_high;
  logic        busy, overrun;

  logic        auto_ack = 1'b0;
  logic        ack_low_a = 1'b0, ack_high_a = 1'b0;
  logic        ack_low_m = 1'b0, ack_high_m = 1'b0;
  logic [15:0] rd_low_a = 16'h0, rd_high_a = 16'h0;
  logic [15:0] rd_low_m = 16'h0, rd_high_m = 16'h0;

  logic [15:0] vram [0:65535];
  logic [15:0] mref [0:65535];

  int checks = 0;
  int errors = 0;

  vram_cpu_port dut (
    .CLK_24M        (clk),
    .nRESET         (rst_n),
    .REG_SEL        (reg_sel),
    .CPU_WR         (cpu_wr),
    .CPU_DIN        (cpu_din),
    .CPU_DOUT       (cpu_dout),
    .VRAM_ADDR      (vram_addr),
    .VRAM_WRITE     (vram_write),
    .nCPU_WR_LOW    (n_wr_low),
    .nCPU_WR_HIGH   (n_wr_high),
    .REQ_LOW        (req_low),
    .REQ_HIGH       (req_high),
    .ACK_LOW        (ack_low_a | ack_low_m),
    .VRAM_LOW_READ  (auto_ack ? rd_low_a : rd_low_m),
    .ACK_HIGH       (ack_high_a | ack_high_m),
    .VRAM_HIGH_READ (auto_ack ? rd_high_a : rd_high_m),
    .BUSY           (busy),
    .OVERRUN        (overrun)
  );

  always #5 clk = ~clk;

  // VRAM responder: random slot latency, backed by vram[]
  initial begin
    logic        hi;
    logic [15:0] idx;
    for (int i = 0; i < 65536; i++)
      vram[i] = 16'(i) ^ 16'hA55A;
    forever begin
      @(negedge clk);
      ack_low_a  = 1'b0;
      ack_high_a = 1'b0;
      if (auto_ack && (req_low || req_high)) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        hi  = req_high;
        idx = {hi, vram_addr};
        if (hi ? !n_wr_high : !n_wr_low)
          vram[idx] = vram_write;
        if (hi) begin
          rd_high_a  = vram[idx];
          ack_high_a = 1'b1;
        end else begin
          rd_low_a  = vram[idx];
          ack_low_a = 1'b1;
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic cpu_write(input logic [1:0] s,
                           input logic [15:0] d);
    @(negedge clk);
    reg_sel = s;
    cpu_din = d;
    cpu_wr  = 1'b1;
    @(negedge clk);
    cpu_wr  = 1'b0;
  endtask

  task automatic read_reg(input logic [1:0] s,
                          output logic [15:0] v);
    reg_sel = s;
    #1;
    v = cpu_dout;
  endtask

  task automatic ack_now(input logic hi,
                         input logic [15:0] d);
    int n = 0;
    while (!(hi ? req_high : req_low) && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL ack_wait: req(hi=%0b) never rose", hi);
    end
    if (hi) begin
      rd_high_m  = d;
      ack_high_m = 1'b1;
    end else begin
      rd_low_m  = d;
      ack_low_m = 1'b1;
    end
    @(negedge clk);
    ack_high_m = 1'b0;
    ack_low_m  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle_timeout: busy=%b want 0",
               tag, busy);
    end
  endtask

  task automatic test_reset();
    logic [15:0] v;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({busy, overrun} !== 2'b00) begin
      errors++;
      $display("FAIL por_flags: got %b want 00",
               {busy, overrun});
    end
    cpu_write(2'd0, 16'h0100);
    ack_now(1'b0, 16'hAAAA);
    cpu_write(2'd1, 16'h5555);
    checks++;
    if (n_wr_low !== 1'b0) begin
      errors++;
      $display("FAIL wr_pend_entry: nwr_low=%b want 0",
               n_wr_low);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({n_wr_low, n_wr_high, req_low, req_high,
         busy, overrun} !== 6'b110000) begin
      errors++;
      $display("FAIL rst_ctrl: got %b want 110000",
               {n_wr_low, n_wr_high, req_low,
                req_high, busy, overrun});
    end
    checks++;
    if (vram_addr !== 15'h0 || vram_write !== 16'h0) begin
      errors++;
      $display("FAIL rst_bus: addr=%h wdata=%h want 0 0",
               vram_addr, vram_write);
    end
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL rst_addr: got %h want 0000", v);
    end
    read_reg(2'd1, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL rst_latch: got %h want 0000", v);
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 16'h0001) begin
      errors++;
      $display("FAIL rst_mod: got %h want 0001", v);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd_low_m  = 16'hDEAD;
    ack_low_m = 1'b1;
    @(negedge clk);
    ack_low_m = 1'b0;
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h0000) begin
      errors++;
      $display("FAIL late_ack_addr: got %h want 0000", v);
    end
    read_reg(2'd1, v);
    checks++;
    if (v !== 16'h0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL late_ack_latch: got %h busy=%b want 0000 0",
               v, busy);
    end
  endtask

  task automatic test_write_step();
    logic [15:0] v;
    int cnt = 0;
    cpu_write(2'd0, 16'h7000);
    ack_now(1'b0, 16'h0000);
    cpu_write(2'd2, 16'h0020);
    cpu_write(2'd1, 16'hBEEF);
    for (int i = 0; i < 5; i++) begin
      if (!n_wr_low) cnt++;
      if (i < 4) @(negedge clk);
    end
    ack_low_m = 1'b1;
    @(negedge clk);
    ack_low_m = 1'b0;
    checks++;
    if (cnt != 5 || n_wr_low !== 1'b1) begin
      errors++;
      $display("FAIL wr_strobe: low_cycles=%0d nwr=%b want 5 1",
               cnt, n_wr_low);
    end
    checks++;
    if (vram_write !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_data: got %h want beef", vram_write);
    end
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h7020 || req_low !== 1'b1) begin
      errors++;
      $display("FAIL step: addr=%h req_low=%b want 7020 1",
               v, req_low);
    end
    ack_now(1'b0, 16'h3C3C);
    read_reg(2'd1, v);
    checks++;
    if (v !== 16'h3C3C) begin
      errors++;
      $display("FAIL post_wr_prefetch: got %h want 3c3c", v);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] v;
    cpu_write(2'd0, 16'h7FFF);
    ack_now(1'b0, 16'h0000);
    cpu_write(2'd2, 16'h0001);
    cpu_write(2'd1, 16'h1111);
    ack_now(1'b0, 16'h0000);
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h0000 || {req_high, req_low} !== 2'b01) begin
      errors++;
      $display("FAIL wrap_low: addr=%h req=%b want 0000 01",
               v, {req_high, req_low});
    end
    ack_now(1'b0, 16'h2222);
    cpu_write(2'd0, 16'hFFFF);
    ack_now(1'b1, 16'h0000);
    cpu_write(2'd2, 16'h8001);
    cpu_write(2'd1, 16'h3333);
    ack_now(1'b1, 16'h0000);
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h8000 || {req_high, req_low} !== 2'b10) begin
      errors++;
      $display("FAIL wrap_high: addr=%h req=%b want 8000 10",
               v, {req_high, req_low});
    end
    ack_now(1'b1, 16'h4444);
    read_reg(2'd1, v);
    checks++;
    if (v !== 16'h4444) begin
      errors++;
      $display("FAIL wrap_high_rd: got %h want 4444", v);
    end
    read_reg(2'd2, v);
    checks++;
    if (v !== 16'h8001) begin
      errors++;
      $display("FAIL mod_rb: got %h want 8001", v);
    end
  endtask

  task automatic test_prefetch();
    logic [15:0] v;
    cpu_write(2'd0, 16'h8010);
    checks++;
    if ({req_high, req_low, busy} !== 3'b101) begin
      errors++;
      $display("FAIL pf_req: got %b want 101",
               {req_high, req_low, busy});
    end
    rd_low_m  = 16'hBAD0;
    ack_low_m = 1'b1;
    @(negedge clk);
    ack_low_m = 1'b0;
    checks++;
    if (busy !== 1'b1 || req_high !== 1'b1) begin
      errors++;
      $display("FAIL pf_wrong_ack: busy=%b req_high=%b want 1 1",
               busy, req_high);
    end
    ack_now(1'b1, 16'h1234);
    read_reg(2'd1, v);
    checks++;
    if (v !== 16'h1234 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pf_data: got %h busy=%b want 1234 0",
               v, busy);
    end
  endtask

  task automatic test_same_edge();
    logic [15:0] v;
    cpu_write(2'd0, 16'h0300);
    ack_now(1'b0, 16'h0000);
    cpu_write(2'd2, 16'h0001);
    cpu_write(2'd1, 16'h7777);
    ack_low_m = 1'b1;
    reg_sel   = 2'd0;
    cpu_din   = 16'h4567;
    cpu_wr    = 1'b1;
    @(negedge clk);
    ack_low_m = 1'b0;
    cpu_wr    = 1'b0;
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h0301 || busy !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_step: addr=%h busy=%b want 0301 1",
               v, busy);
    end
    ack_now(1'b0, 16'h5A5A);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL same_edge_queued: busy=%b want 1", busy);
    end
    ack_now(1'b0, 16'h6B6B);
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h4567 || busy !== 1'b0) begin
      errors++;
      $display("FAIL same_edge_final: addr=%h busy=%b want 4567 0",
               v, busy);
    end
    read_reg(2'd1, v);
    checks++;
    if (v !== 16'h6B6B) begin
      errors++;
      $display("FAIL same_edge_rd: got %h want 6b6b", v);
    end
  endtask

  task automatic test_queue_overrun();
    logic [15:0] v;
    logic [15:0] a, b, c;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    cpu_write(2'd0, 16'h0200);
    ack_now(1'b0, 16'h0000);
    cpu_write(2'd2, 16'h0001);
    @(negedge clk);
    reg_sel = 2'd1;
    cpu_din = a;
    cpu_wr  = 1'b1;
    @(negedge clk);
    cpu_din = b;
    @(negedge clk);
    cpu_din = c;
    @(negedge clk);
    cpu_wr  = 1'b0;
    checks++;
    if ({overrun, busy} !== 2'b11) begin
      errors++;
      $display("FAIL overrun_flag: got %b want 11",
               {overrun, busy});
    end
    auto_ack = 1'b1;
    wait_idle("queue");
    auto_ack = 1'b0;
    checks++;
    if (vram[16'h0200] !== a || vram[16'h0201] !== b) begin
      errors++;
      $display("FAIL queue_data: got %h %h want %h %h",
               vram[16'h0200], vram[16'h0201], a, b);
    end
    checks++;
    if (vram[16'h0202] !== (16'h0202 ^ 16'hA55A)) begin
      errors++;
      $display("FAIL dropped_write: got %h want %h",
               vram[16'h0202], 16'h0202 ^ 16'hA55A);
    end
    read_reg(2'd0, v);
    checks++;
    if (v !== 16'h0202 || overrun !== 1'b1) begin
      errors++;
      $display("FAIL queue_addr: addr=%h ovr=%b want 0202 1",
               v, overrun);
    end
  endtask

  task automatic test_random();
    logic [15:0] ma, mm, ml, d, v;
    logic [1:0]  s;
    int diffs = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 65536; i++) mref[i] = vram[i];
    ma = 16'h0000;
    mm = 16'h0001;
    ml = 16'h0000;
    auto_ack = 1'b1;
    for (int it = 0; it < 60; it++) begin
      s = 2'($urandom_range(0, 3));
      d = 16'($urandom);
      cpu_write(s, d);
      wait_idle("rnd");
      case (s)
        2'd0: begin
          ma = d;
          ml = mref[ma];
        end
        2'd1: begin
          mref[ma] = d;
          ma = {ma[15], 15'(ma[14:0] + mm[14:0])};
          ml = mref[ma];
        end
        2'd2: mm = d;
        default: ;
      endcase
      read_reg(2'd0, v);
      checks++;
      if (v !== ma) begin
        errors++;
        $display("FAIL rnd_addr it%0d: got %h want %h", it, v, ma);
      end
      read_reg(2'd1, v);
      checks++;
      if (v !== ml) begin
        errors++;
        $display("FAIL rnd_latch it%0d: got %h want %h", it, v, ml);
      end
      read_reg(2'd2, v);
      checks++;
      if (v !== mm) begin
        errors++;
        $display("FAIL rnd_mod it%0d: got %h want %h", it, v, mm);
      end
      read_reg(2'd3, v);
      checks++;
      if (v !== 16'h0000) begin
        errors++;
        $display("FAIL rnd_rsvd it%0d: got %h want 0000", it, v);
      end
    end
    auto_ack = 1'b0;
    for (int i = 0; i < 65536; i++)
      if (vram[i] !== mref[i]) diffs++;
    checks++;
    if (diffs != 0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL rnd_mem: diffs=%0d ovr=%b want 0 0",
               diffs, overrun);
    end
  endtask

  initial begin
    test_reset();
    test_write_step();
    test_wrap();
    test_prefetch();
    test_same_edge();
    test_queue_overrun();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
